// File: rtl/reg_file_bist_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_bist_pkg
// Shared definitions for the register-file BIST controller:
//   - stateT        : controller FSM state encoding
//   - DEF_ADDR_W    : default register address width
//   - DEF_DATA_W    : default register data width
//   - DEF_PATTERN   : default phase-0 base pattern
//   - EXP_W         : working width of expected(); wide enough for any DATA_W
//                     up to 64 bits, callers cast the result down
//   - expected()    : test value for a given register index and phase
// -----------------------------------------------------------------------------
package reg_file_bist_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WRITE0 = 3'd1,
        READ0  = 3'd2,
        WRITE1 = 3'd3,
        READ1  = 3'd4,
        DONE   = 3'd5
    } stateT;

    localparam int          DEF_ADDR_W  = 3;
    localparam int          DEF_DATA_W  = 32;
    localparam logic [31:0] DEF_PATTERN = 32'hFF00FF00;
    localparam int          EXP_W       = 64;

    // Phase 0 writes the pattern XORed with the zero-extended index so every
    // register holds a distinct value; phase 1 writes the bitwise inverse so
    // each bit cell is exercised at both polarities.
    function automatic logic [EXP_W-1:0] expected(
        input logic [EXP_W-1:0] pattern,
        input logic [EXP_W-1:0] idx,
        input logic             phase
    );
        logic [EXP_W-1:0] base;
        base = pattern ^ idx;
        return phase ? ~base : base;
    endfunction

endpackage

// File: rtl/reg_file_bist_chk.sv
// -----------------------------------------------------------------------------
// reg_file_bist_chk
// Read-data checker for the register-file BIST.
// Ports:
//   clk       in   system clock
//   reset_n   in   synchronous active-low reset
//   clear     in   start of a new run: clears the error count and fail address
//   cmpEn     in   a read is in progress this cycle; compare rData
//   phase     in   0 = pattern phase, 1 = inverted phase
//   idx       in   register index being read
//   rData     in   register-file read data for idx
//   mismatch  out  combinational: rData differs from the expected value
//   errCnt    out  registered mismatch count, saturating at all-ones
//   failAddr  out  registered index of the first mismatch of the run
// -----------------------------------------------------------------------------
module reg_file_bist_chk
    import reg_file_bist_pkg::*;
#(
    parameter int                ADDR_W  = DEF_ADDR_W,
    parameter int                DATA_W  = DEF_DATA_W,
    parameter logic [DATA_W-1:0] PATTERN = DATA_W'(DEF_PATTERN)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              cmpEn,
    input  logic              phase,
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] rData,
    output logic              mismatch,
    output logic [ADDR_W+1:0] errCnt,
    output logic [ADDR_W-1:0] failAddr
);

    logic [DATA_W-1:0] expData;

    assign expData  = DATA_W'(expected(EXP_W'(PATTERN), EXP_W'(idx), phase));
    assign mismatch = cmpEn && (rData != expData);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            errCnt   <= '0;
            failAddr <= '0;
        end else if (clear) begin
            errCnt   <= '0;
            failAddr <= '0;
        end else if (mismatch) begin
            // errCnt never wraps back to zero, so zero means "no failure yet".
            if (errCnt == '0) begin
                failAddr <= idx;
            end
            if (errCnt != '1) begin
                errCnt <= errCnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_file_bist.sv
// -----------------------------------------------------------------------------
// reg_file_bist
// BIST initiator for a register file: fills every register with a pattern,
// reads them back and checks, then repeats with the inverted pattern.
// Optional build macro: REG_FILE_BIST_STOP_ON_FAIL_EN -- when defined, the
// first read mismatch ends the run immediately (straight to DONE).
// Ports:
//   clk        in   system clock
//   reset_n    in   synchronous active-low reset
//   start      in   begin a run (honoured only in IDLE or DONE)
//   we         out  register-file write enable
//   wAddr      out  register-file write address
//   wData      out  register-file write data
//   rAddr      out  register-file read address
//   rData      in   register-file read data (combinational read of rAddr)
//   busy       out  run in progress (WRITE0 .. READ1)
//   done       out  run finished; held until next start or reset
//   pass       out  valid with done: 1 when no mismatch was seen
//   err_cnt    out  saturating mismatch count
//   fail_addr  out  address of the first mismatch (0 if none)
// -----------------------------------------------------------------------------
module reg_file_bist
    import reg_file_bist_pkg::*;
#(
    parameter int                ADDR_W  = DEF_ADDR_W,
    parameter int                DATA_W  = DEF_DATA_W,
    parameter logic [DATA_W-1:0] PATTERN = DATA_W'(DEF_PATTERN)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic              we,
    output logic [ADDR_W-1:0] wAddr,
    output logic [DATA_W-1:0] wData,
    output logic [ADDR_W-1:0] rAddr,
    input  logic [DATA_W-1:0] rData,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W+1:0] err_cnt,
    output logic [ADDR_W-1:0] fail_addr
);

    localparam logic [ADDR_W-1:0] LAST_IDX = '1;

    stateT             stateReg;
    stateT             stateNext;
    logic [ADDR_W-1:0] idxReg;
    logic [ADDR_W-1:0] idxNext;
    logic              startAccept;
    logic              cmpEn;
    logic              mismatch;
    logic              writingNext;
    logic              readingNext;
    logic              cleanNext;

    assign cmpEn = (stateReg == READ0) || (stateReg == READ1);

    reg_file_bist_chk #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .PATTERN (PATTERN)
    ) chk (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (startAccept),
        .cmpEn    (cmpEn),
        .phase    (stateReg == READ1),
        .idx      (idxReg),
        .rData    (rData),
        .mismatch (mismatch),
        .errCnt   (err_cnt),
        .failAddr (fail_addr)
    );

    always_comb begin
        stateNext   = stateReg;
        idxNext     = idxReg;
        startAccept = 1'b0;
        case (stateReg)
            IDLE, DONE: begin
                if (start) begin
                    stateNext   = WRITE0;
                    idxNext     = '0;
                    startAccept = 1'b1;
                end
            end
            WRITE0: begin
                stateNext = (idxReg == LAST_IDX) ? READ0 : WRITE0;
                idxNext   = (idxReg == LAST_IDX) ? '0 : idxReg + 1'b1;
            end
            READ0: begin
                stateNext = (idxReg == LAST_IDX) ? WRITE1 : READ0;
                idxNext   = (idxReg == LAST_IDX) ? '0 : idxReg + 1'b1;
            end
            WRITE1: begin
                stateNext = (idxReg == LAST_IDX) ? READ1 : WRITE1;
                idxNext   = (idxReg == LAST_IDX) ? '0 : idxReg + 1'b1;
            end
            READ1: begin
                stateNext = (idxReg == LAST_IDX) ? DONE : READ1;
                idxNext   = (idxReg == LAST_IDX) ? '0 : idxReg + 1'b1;
            end
            default: begin
                stateNext = IDLE;
                idxNext   = '0;
            end
        endcase
`ifdef REG_FILE_BIST_STOP_ON_FAIL_EN
        if (mismatch) begin
            stateNext = DONE;
            idxNext   = '0;
        end
`endif
    end

    assign writingNext = (stateNext == WRITE0) || (stateNext == WRITE1);
    assign readingNext = (stateNext == READ0) || (stateNext == READ1);
    // The count as it will stand after this edge: nothing seen so far and no
    // mismatch on the compare closing this cycle.
    assign cleanNext   = (err_cnt == '0) && !mismatch;

    // Outputs are registered from the next state/index so they describe the
    // cycle that the edge opens.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stateReg <= IDLE;
            idxReg   <= '0;
            we       <= 1'b0;
            wAddr    <= '0;
            wData    <= '0;
            rAddr    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            stateReg <= stateNext;
            idxReg   <= idxNext;
            we       <= writingNext;
            wAddr    <= writingNext ? idxNext : '0;
            wData    <= writingNext
                        ? DATA_W'(expected(EXP_W'(PATTERN), EXP_W'(idxNext), stateNext == WRITE1))
                        : '0;
            rAddr    <= readingNext ? idxNext : '0;
            busy     <= writingNext || readingNext;
            done     <= (stateNext == DONE);
            pass     <= (stateNext == DONE) && cleanNext;
        end
    end

endmodule

// File: tb/tb_reg_file_bist.sv
// -----------------------------------------------------------------------------
// tb_reg_file_bist
// Directed bench for reg_file_bist with an 8x32 register file model attached.
// The model can flip rData[0] of register 3 while it still holds its phase-0
// value, or force rData to zero.
// -----------------------------------------------------------------------------
module tb_reg_file_bist;

    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;
    localparam logic [31:0] PAT = 32'hFF00FF00;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic              we;
    logic [ADDR_W-1:0] wAddr;
    logic [DATA_W-1:0] wData;
    logic [ADDR_W-1:0] rAddr;
    logic [DATA_W-1:0] rData;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ADDR_W+1:0] err_cnt;
    logic [ADDR_W-1:0] fail_addr;

    int checks   = 0;
    int failures = 0;
    int faultMode = 0;   // 0 none, 1 flip bit0 of reg 3 in phase 0, 2 stuck at 0

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    reg_file_bist dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .we        (we),
        .wAddr     (wAddr),
        .wData     (wData),
        .rAddr     (rAddr),
        .rData     (rData),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_cnt   (err_cnt),
        .fail_addr (fail_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (we) mem[wAddr] <= wData;
    end

    always_comb begin
        rData = mem[rAddr];
        if (faultMode == 1 && rAddr == 3'd3 && mem[3] == 32'hFF00FF03) rData[0] = ~rData[0];
        if (faultMode == 2) rData = '0;
    end

    function automatic logic [31:0] expVal(input int idx, input bit phase);
        logic [31:0] b;
        b = PAT ^ 32'(idx);
        return phase ? ~b : b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkIdle(input string tag);
        chk({tag, "_we"}, 64'(we), 64'd0);
        chk({tag, "_wAddr"}, 64'(wAddr), 64'd0);
        chk({tag, "_wData"}, 64'(wData), 64'd0);
        chk({tag, "_rAddr"}, 64'(rAddr), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_pass"}, 64'(pass), 64'd0);
        chk({tag, "_err"}, 64'(err_cnt), 64'd0);
        chk({tag, "_faddr"}, 64'(fail_addr), 64'd0);
    endtask

    // Full cycle-by-cycle check of a fault-free run. Caller is in the cycle
    // before the start edge. pulseAt >= 0 re-pulses start in that run cycle.
    task automatic runClean(input string tag, input int pulseAt);
        int errs;
        errs = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_startclr_done"}, 64'(done), 64'd0);
        chk({tag, "_startclr_pass"}, 64'(pass), 64'd0);
        chk({tag, "_startclr_err"}, 64'(err_cnt), 64'd0);
        for (int c = 0; c < 32; c++) begin
            int  i;
            bit  wr;
            bit  ph;
            bit  ok;
            i  = c % 8;
            wr = (c < 8) || (c >= 16 && c < 24);
            ph = (c >= 16);
            ok = (busy === 1'b1) && (we === wr);
            if (wr) ok = ok && (wAddr === 3'(i)) && (wData === expVal(i, ph));
            else    ok = ok && (rAddr === 3'(i));
            if (!ok) begin
                errs++;
                $display("cycle %0d: busy=%0b we=%0b wAddr=%0d wData=%h rAddr=%0d", c, busy, we, wAddr, wData, rAddr);
            end
            if (c == pulseAt) start = 1'b1;
            tick();
            start = 1'b0;
        end
        chk({tag, "_seq_errors"}, 64'(errs), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_pass"}, 64'(pass), 64'd1);
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        chk({tag, "_err"}, 64'(err_cnt), 64'd0);
        chk({tag, "_faddr"}, 64'(fail_addr), 64'd0);
        chk({tag, "_we_end"}, 64'(we), 64'd0);
        $display("run %s: done=%0b pass=%0b err_cnt=%0d", tag, done, pass, err_cnt);
    endtask

    // Start a run and count busy/we cycles until done, bounded.
    task automatic runMeasure(output int busyCycles, output int weCycles);
        busyCycles = 0;
        weCycles   = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (done) break;
            if (busy) busyCycles++;
            if (we) weCycles++;
            tick();
        end
        chk("done_in_time", 64'(done), 64'd1);
    endtask

    initial begin
        int bc;
        int wc;
        int weSeen;
        reset_n = 1'b0;
        start   = 1'b0;

        // Reset then idle
        tick();
        tick();
        chkIdle("reset");
        reset_n = 1'b1;
        weSeen = 0;
        for (int n = 0; n < 20; n++) begin
            if (we) weSeen++;
            tick();
        end
        chk("idle_no_we", 64'(weSeen), 64'd0);
        $display("reset/idle: we cycles=%0d", weSeen);

        // Clean run, with start re-pulsed during READ0 (ignored)
        runClean("clean", 10);

        // Start from DONE restarts and clears done/pass
        runClean("restart", -1);

        // Flip rData[0] of register 3 in phase 0
        faultMode = 1;
        runMeasure(bc, wc);
        faultMode = 0;
`ifdef REG_FILE_BIST_STOP_ON_FAIL_EN
        chk("flip_busy", 64'(bc), 64'd12);
        chk("flip_we", 64'(wc), 64'd8);
`else
        chk("flip_busy", 64'(bc), 64'd32);
        chk("flip_we", 64'(wc), 64'd16);
`endif
        chk("flip_pass", 64'(pass), 64'd0);
        chk("flip_err", 64'(err_cnt), 64'd1);
        chk("flip_faddr", 64'(fail_addr), 64'd3);
        $display("fault flip: busy=%0d we=%0d err_cnt=%0d fail_addr=%0d", bc, wc, err_cnt, fail_addr);

        // Stuck-at-zero read data
        faultMode = 2;
        runMeasure(bc, wc);
        faultMode = 0;
`ifdef REG_FILE_BIST_STOP_ON_FAIL_EN
        chk("stuck_busy", 64'(bc), 64'd9);
        chk("stuck_we", 64'(wc), 64'd8);
        chk("stuck_err", 64'(err_cnt), 64'd1);
`else
        chk("stuck_busy", 64'(bc), 64'd32);
        chk("stuck_we", 64'(wc), 64'd16);
        chk("stuck_err", 64'(err_cnt), 64'd16);
`endif
        chk("stuck_pass", 64'(pass), 64'd0);
        chk("stuck_faddr", 64'(fail_addr), 64'd0);
        $display("stuck zero: busy=%0d we=%0d err_cnt=%0d fail_addr=%0d", bc, wc, err_cnt, fail_addr);

        // Reset mid-run during WRITE1 at idx 4 (run cycle 20)
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        chk("mid_we", 64'(we), 64'd1);
        chk("mid_wAddr", 64'(wAddr), 64'd4);
        chk("mid_wData", 64'(wData), 64'(expVal(4, 1'b1)));
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chkIdle("midreset");
        weSeen = 0;
        for (int n = 0; n < 5; n++) begin
            if (we || busy) weSeen++;
            tick();
        end
        chk("midreset_no_activity", 64'(weSeen), 64'd0);
        $display("mid-run reset: activity cycles after reset=%0d", weSeen);
        runClean("after_reset", -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file_bist.md
Name: reg_file_bist

Overview:
Built-in self-test controller that acts as the initiator on the register-file write/read port pair. It drives we/wAddr/wData to fill every register with a pattern, then drives rAddr and checks rData against the expected value. It runs two phases: pattern, then inverted pattern. It sits beside the register file in the datapath and reports pass/fail to the top-level control.

Parameters:
ADDR_W, 3, register address width; NUM_REGS = 2**ADDR_W
DATA_W, 32, register data width
PATTERN, 32'hFF00FF00, phase-0 base pattern (DATA_W bits)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset_n  in  1  reset; one clock, synchronous, active-low
start  in  1  begin a test run; sampled only in IDLE or DONE
we  out  1  register-file write enable
wAddr  out  ADDR_W  register-file write address
wData  out  DATA_W  register-file write data
rAddr  out  ADDR_W  register-file read address
rData  in  DATA_W  register-file read data; combinational read of rAddr
busy  out  1  high from the first WRITE0 cycle through the last READ1 cycle
done  out  1  high in DONE; held until next start or reset
pass  out  1  valid while done=1; 1 when err_cnt==0
err_cnt  out  ADDR_W+2  mismatch count, saturating at all-ones
fail_addr  out  ADDR_W  address of the first mismatch; 0 if none

Behaviour:
- All outputs are registered. Reset when reset_n=0 at a rising edge: state=IDLE, idx=0, all outputs 0.
- Reset mid-run aborts immediately. No further writes are issued; the next run needs a new start.
- FSM states: IDLE, WRITE0, READ0, WRITE1, READ1, DONE.
- IDLE/DONE with start=1 at edge k: go to WRITE0, idx=0, clear done/pass/err_cnt/fail_addr. The first write is visible in cycle k+1.
- start is ignored while busy.
- expected(idx, phase):
  - phase 0 = PATTERN ^ zero-extended idx
  - phase 1 = bitwise inverse of phase 0
- WRITE phase:
  - we=1, wAddr=idx, wData=expected(idx, phase); one register per cycle.
  - On idx==NUM_REGS-1, set idx=0 and go to the matching READ state.
  - we is deasserted in the first READ cycle.
- READ phase:
  - rAddr=idx; rData is compared against expected(idx, phase) at the closing edge of that same cycle.
  - On mismatch, increment err_cnt (saturating). If this is the first mismatch of the run, capture fail_addr=idx.
  - On idx==NUM_REGS-1: READ0 goes to WRITE1, READ1 goes to DONE.
- Run length is 4*NUM_REGS cycles: 32 at the defaults. done rises at the edge ending the last READ1 cycle.
- idx wraps only via state transitions; it never exceeds NUM_REGS-1.
- The last READ0 compare and the transition to WRITE1 happen on the same edge. The compare uses the phase-0 expected value.
- In IDLE/DONE: we=0; wAddr/wData/rAddr hold 0.

Optional Feature:
REG_FILE_BIST_STOP_ON_FAIL_EN
- Defined: the first mismatch goes straight to DONE on the same edge, with err_cnt=1, fail_addr captured, pass=0, and no further writes or reads.
- Undefined: the full 4*NUM_REGS-cycle run always completes and err_cnt counts every mismatch.

Decomposition:
- Package reg_file_bist_pkg holds:
  - state enum
  - default ADDR_W/DATA_W/PATTERN constants
  - function expected(idx, phase)
- One natural sub-module: reg_file_bist_chk. It contains the comparator, saturating err_cnt and first-fail capture, and is driven by a compare-enable, idx and rData.
- The FSM, idx counter and port drive stay in the top.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles, start=0 -> all outputs 0; we never asserts over 20 cycles.
- Clean run with the 8x32 register file attached: start pulse at edge k.
  - Writes FF00FF00..FF00FF07 at addresses 0..7, then reads.
  - Then writes 00FF00FF..00FF00F8.
  - done=1 and pass=1 after edge k+32; err_cnt=0; busy high for exactly 32 cycles.
- Fault injection: bench flips rData[0] when rAddr==3 in READ0 -> done, pass=0, err_cnt=1, fail_addr=3.
- Stuck data: rData forced to 0 for the whole run -> err_cnt=16, fail_addr=0. With REG_FILE_BIST_STOP_ON_FAIL_EN: done one edge into READ0, err_cnt=1, and no WRITE1 writes occur.
- Reset mid-run: reset_n=0 during WRITE1 at idx=4 -> next cycle IDLE with all outputs 0; a new start runs a clean 32-cycle pass.
- start while busy: re-pulse start in READ0 -> ignored and run length unchanged. start in DONE -> restarts, clearing done/pass on the first WRITE0 cycle.
